// File: rtl/rfarb_pkg.sv
// Shared constants and helpers for the regfile write-port arbiter.
package rfarb_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic WriteEnable  = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam logic [RegAddrBus-1:0] ZeroAddr = '0;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/regfile_wr_arb_rr_arbiter.sv
// Combinational round-robin picker: search begins one past ptr_i.
// Shared shape with a future read-port arbiter.
module rr_arbiter
  import rfarb_pkg::*;
#(
  parameter int N = 3,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  int            sum;
  logic [IW-1:0] k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    sum   = 0;
    k     = '0;
    if (en_i) begin
      for (int off = 1; off <= N; off++) begin
        sum = int'(ptr_i) + off;
        if (sum >= N) sum = sum - N;
        k = IW'(sum);
        if (!any_o && req_i[k]) begin
          gnt_o[k] = 1'b1;
          idx_o    = k;
          any_o    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arb.sv
// Round-robin arbiter for the single regfile write port, registered output.
// Optional RFARB_STARVE_CNT_EN adds starve_clr / starve_max monitoring.
module regfile_wr_arb
  import rfarb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = RegAddrBus,
  parameter int DATA_W  = RegBus,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic                      we,
  output logic [ADDR_W-1:0]         waddr,
  output logic [DATA_W-1:0]         wdata,
  output logic [IDX_W-1:0]          gnt_id
`ifdef RFARB_STARVE_CNT_EN
  ,
  input  logic                      starve_clr,
  output logic [7:0]                starve_max
`endif
);

  logic [ADDR_W-1:0] addr_a [NUM_REQ];
  logic [DATA_W-1:0] data_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
    assign data_a[g] = req_data[g*DATA_W +: DATA_W];
  end

  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  waddr_q, waddr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;
  logic [ADDR_W-1:0]  sel_addr;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .en_i  (!stall && !rst),
    .gnt_o (gnt),
    .idx_o (gnt_idx),
    .any_o (gnt_any)
  );

  assign req_ready = gnt;
  assign sel_addr  = addr_a[gnt_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we_d     = WriteDisable;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    gnt_id_d = gnt_id_q;
    if (gnt_any) begin
      rr_ptr_d = gnt_idx;
      waddr_d  = sel_addr;
      wdata_d  = data_a[gnt_idx];
      gnt_id_d = gnt_idx;
      // r0 is hardwired: accept the request but drop the write
      we_d     = (sel_addr != ADDR_W'(ZeroAddr)) ? WriteEnable : WriteDisable;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= IDX_W'(NUM_REQ - 1);
      we_q     <= WriteDisable;
      waddr_q  <= '0;
      wdata_q  <= '0;
      gnt_id_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  assign we     = we_q;
  assign waddr  = waddr_q;
  assign wdata  = wdata_q;
  assign gnt_id = gnt_id_q;

`ifdef RFARB_STARVE_CNT_EN
  logic [7:0] cnt_q [NUM_REQ];
  logic [7:0] cnt_d [NUM_REQ];
  logic [7:0] max_q, max_d;

  always_comb begin
    max_d = max_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = '0;
      if (req_valid[i] && !gnt[i])
        cnt_d[i] = (cnt_q[i] == 8'hFF) ? 8'hFF : cnt_q[i] + 8'd1;
      if (cnt_d[i] > max_d) max_d = cnt_d[i];
    end
    if (starve_clr) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_d[i] = '0;
      max_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
      max_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
      max_q <= max_d;
    end
  end

  assign starve_max = max_q;
`endif

endmodule
